// File: rtl/fifo_serial_tx_if.sv
// FIFO read port and 3-wire serial link of the FIFO drain stage.
interface fifo_serial_tx_if #(
    parameter int DATA_W = 24
) ();
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              sclk;
    logic              sdata;
    logic              fsync;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en,
        output sclk,
        output sdata,
        output fsync
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en,
        input  sclk,
        input  sdata,
        input  fsync
    );
endinterface

// File: rtl/fifo_serial_tx.sv
// FIFO drain stage: fetches words into a one-word hold register and shifts them
// MSB-first on sclk/sdata/fsync, gapless when the next word is already held.
//
// state   | meaning
// F_IDLE  | no read outstanding; may strike fifo_rd_en
// F_WAIT  | read struck last cycle; fifo_data captured into hold at this edge
// S_IDLE  | link quiet, sclk/sdata/fsync low
// S_SHIFT | a word is on the link
module fifo_serial_tx #(
    parameter int DATA_W  = 24,
    parameter int BIT_CYC = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    fifo_serial_tx_if.master link,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] tx_count
);
    localparam int BC_W = $clog2(BIT_CYC);
    localparam int BI_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] CYC_LAST = BC_W'(BIT_CYC - 1);
    localparam logic [BC_W-1:0] CYC_HALF = BC_W'(BIT_CYC / 2);
    localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_W - 1);

    typedef enum logic {F_IDLE, F_WAIT} fetch_t;
    typedef enum logic {S_IDLE, S_SHIFT} shift_t;

    fetch_t            f_state, f_next;
    shift_t            s_state, s_next;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              hold_valid;
    logic [BI_W-1:0]   bit_cnt;
    logic [BC_W-1:0]   cyc_cnt;
    logic              rd_en;
    logic              word_end;
    logic              load;

    always_comb begin
        f_next = f_state;
        rd_en  = 1'b0;
        if (f_state == F_IDLE) begin
            if (tx_en && !link.fifo_empty && !hold_valid) begin
                rd_en  = 1'b1;
                f_next = F_WAIT;
            end
        end else begin
            f_next = F_IDLE;
        end
        if (reset) begin
            rd_en = 1'b0;
        end
    end

    always_comb begin
        word_end = (s_state == S_SHIFT) && (bit_cnt == BIT_LAST) && (cyc_cnt == CYC_LAST);
        load     = ((s_state == S_IDLE) || word_end) && tx_en && hold_valid;
        s_next   = s_state;
        if (load) begin
            s_next = S_SHIFT;
        end else if (word_end) begin
            s_next = S_IDLE;
        end
        underrun = word_end && tx_en && !hold_valid && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state    <= F_IDLE;
            s_state    <= S_IDLE;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            tx_count   <= '0;
        end else begin
            f_state <= f_next;
            s_state <= s_next;

            // Capture and load are mutually exclusive: a capture needs hold_valid=0.
            if (f_state == F_WAIT) begin
                hold_reg   <= link.fifo_data;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            if (load) begin
                shift_reg <= hold_reg;
                bit_cnt   <= '0;
                cyc_cnt   <= '0;
            end else if (word_end) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                cyc_cnt   <= '0;
            end else if (s_state == S_SHIFT) begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_cnt   <= '0;
                    bit_cnt   <= bit_cnt + 1'b1;
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                end else begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                end
            end

            if (word_end) begin
                tx_count <= tx_count + 1'b1;
            end
        end
    end

    assign link.fifo_rd_en = rd_en;
    assign link.sclk       = (s_state == S_SHIFT) && (cyc_cnt >= CYC_HALF);
    assign link.sdata      = (s_state == S_SHIFT) && shift_reg[DATA_W-1];
    assign link.fsync      = (s_state == S_SHIFT) && (bit_cnt == '0);
    assign busy            = (s_state == S_SHIFT);
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model plus a word-level reference of the serial frame,
// checked every cycle on the falling clock edge.
module tb_fifo_serial_tx;
    localparam int DATA_W   = 24;
    localparam int BIT_CYC  = 4;
    localparam int CNT_W    = 4;
    localparam int WORD_CYC = DATA_W * BIT_CYC;

    logic             clk;
    logic             reset;
    logic             tx_en;
    logic             busy;
    logic             underrun;
    logic [CNT_W-1:0] tx_count;

    fifo_serial_tx_if #(.DATA_W(DATA_W)) bus ();

    fifo_serial_tx #(.DATA_W(DATA_W), .BIT_CYC(BIT_CYC), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_en    (tx_en),
        .link     (bus),
        .busy     (busy),
        .underrun (underrun),
        .tx_count (tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur_word = '0;
    bit               rx_active = 1'b0;
    int               k = 0;
    logic [CNT_W-1:0] exp_count = '0;
    bit               rst_prev = 1'b1;
    bit               prev_rd = 1'b0;
    int               n_cyc = 0;
    int               rd_pulses = 0;
    int               und_pulses = 0;
    int               und_model = 0;
    int               idle_rd_cyc = -1;
    int               busy_run = 0;
    int               busy_run_max = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: check this cycle's outputs at negedge, then advance the FIFO model.
    task automatic step();
        logic rd_now;
        logic rst_now;
        logic exp_und;
        @(negedge clk);
        n_cyc++;
        rd_now  = bus.fifo_rd_en;
        rst_now = reset;
        if (rst_now) chk("rd_en_in_reset", rd_now, 1'b0);
        if (rst_prev) begin
            chk("rst_busy", busy, 1'b0);
            chk("rst_sclk", bus.sclk, 1'b0);
            chk("rst_sdata", bus.sdata, 1'b0);
            chk("rst_fsync", bus.fsync, 1'b0);
            chk("rst_underrun", underrun, 1'b0);
            chk("rst_tx_count", tx_count, '0);
            rx_active = 1'b0;
            busy_run  = 0;
        end else begin
            chk("tx_count", tx_count, exp_count);
            if (!rx_active && busy) begin
                chk("word_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur_word  = exp_q.pop_front();
                    rx_active = 1'b1;
                    k         = 0;
                    if (idle_rd_cyc >= 0) chk("start_latency", n_cyc - idle_rd_cyc, 3);
                    idle_rd_cyc = -1;
                end
            end
            if (rd_now) begin
                rd_pulses++;
                chk("rd_en_rate", prev_rd, 1'b0);
                chk("rd_en_tx_en", tx_en, 1'b1);
                chk("rd_en_fifo_nonempty", fifo_q.size() > 0, 1'b1);
                if (!rx_active) idle_rd_cyc = n_cyc;
            end
            if (underrun) und_pulses++;
            if (busy) begin
                busy_run++;
                if (busy_run > busy_run_max) busy_run_max = busy_run;
            end else begin
                busy_run = 0;
            end
            if (rx_active) begin
                chk("busy", busy, 1'b1);
                chk("sclk", bus.sclk, (k % BIT_CYC) >= (BIT_CYC / 2));
                chk("fsync", bus.fsync, k < BIT_CYC);
                chk("sdata", bus.sdata, cur_word[DATA_W-1-(k/BIT_CYC)]);
                if (k == WORD_CYC - 1) begin
                    exp_und = tx_en && (exp_q.size() == 0);
                    chk("underrun_end", underrun, exp_und);
                    if (exp_und) und_model++;
                    exp_count++;
                    if (tx_en && exp_q.size() > 0) begin
                        cur_word = exp_q.pop_front();
                        k        = 0;
                    end else begin
                        rx_active = 1'b0;
                    end
                end else begin
                    chk("underrun_mid", underrun, 1'b0);
                    k++;
                end
            end else begin
                chk("idle_busy", busy, 1'b0);
                chk("idle_sclk", bus.sclk, 1'b0);
                chk("idle_sdata", bus.sdata, 1'b0);
                chk("idle_fsync", bus.fsync, 1'b0);
                chk("idle_underrun", underrun, 1'b0);
            end
        end
        prev_rd = rd_now;
        @(posedge clk);
        #1;
        rst_prev = rst_now;
        if (rd_now && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic release_reset();
        fifo_q.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
        exp_count      = '0;
        rx_active      = 1'b0;
        idle_rd_cyc    = -1;
        reset          = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        release_reset();
        step();
    endtask

    task automatic run_to_k(input int target, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(rx_active && k == target) && n < max);
        chk("run_to_k_timeout", rx_active && k == target, 1'b1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((rx_active || exp_q.size() > 0) && n < max);
        chk("wait_idle_timeout", rx_active || exp_q.size() > 0, 1'b0);
        repeat (4) step();
    endtask

    initial begin
        int r0, u0, um0, nw;
        reset          = 1'b1;
        tx_en          = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        repeat (3) step();
        release_reset();
        repeat (3) step();

        // reset held 3 clk mid-word with a word still in the FIFO
        push(24'h123456); push(24'hFEDCBA); push(24'h0F0F0F);
        tx_en = 1'b1;
        run_to_k(50, 300);
        do_reset(3);
        repeat (60) step();
        chk("t1_tx_count", tx_count, '0);

        // reset during bit 10, then FIFO empty: stays idle
        push(24'h5A5A5A);
        run_to_k(10 * BIT_CYC + 1, 300);
        do_reset(1);
        r0 = rd_pulses;
        repeat (120) step();
        chk("t5_no_rd", rd_pulses - r0, 0);
        chk("t5_busy", busy, 1'b0);

        // single word, then underrun and idle
        r0 = rd_pulses; u0 = und_pulses;
        push(24'hA5C30F);
        wait_idle(400);
        chk("t2_rd_pulses", rd_pulses - r0, 1);
        chk("t2_tx_count", tx_count, 1);
        chk("t4_underrun", und_pulses - u0, 1);

        // three back-to-back words
        r0 = rd_pulses; u0 = und_pulses; busy_run_max = 0;
        push(24'h000001); push(24'h800000); push(24'hC3A55A);
        wait_idle(600);
        chk("t3_rd_pulses", rd_pulses - r0, 3);
        chk("t3_busy_run", busy_run_max, 3 * WORD_CYC);
        chk("t3_underrun", und_pulses - u0, 1);
        chk("t3_tx_count", tx_count, 4);

        // tx_en dropped during bit 5 with words queued
        push(24'h6B1D2E); push(24'h39F0C7); push(24'hE4822B);
        run_to_k(5 * BIT_CYC + 2, 300);
        tx_en = 1'b0;
        r0 = rd_pulses; u0 = und_pulses;
        repeat (150) step();
        chk("t6_no_rd", rd_pulses - r0, 0);
        chk("t6_no_underrun", und_pulses - u0, 0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_tx_count", tx_count, 5);
        tx_en = 1'b1;
        wait_idle(600);
        chk("t6_resume_rd", rd_pulses - r0, 1);
        chk("t6_tx_count_end", tx_count, 7);

        // random words and tx_en interruptions; tx_count wraps here
        for (int it = 0; it < 10; it++) begin
            nw = $urandom_range(2, 4);
            r0 = rd_pulses; u0 = und_pulses; um0 = und_model;
            for (int j = 0; j < nw; j++) push(DATA_W'($urandom));
            tx_en = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                run_to_k($urandom_range(8, 90), 400);
                tx_en = 1'b0;
                repeat ($urandom_range(1, 150)) step();
                tx_en = 1'b1;
            end
            wait_idle(2000);
            chk("rand_rd_pulses", rd_pulses - r0, nw);
            chk("rand_underrun", und_pulses - u0, und_model - um0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
